issue_scoreboard: RTL and testbench

//  Sequences instr_decode output into execute. Holds one issued instr in an output register and

---
 rtl/issue_scoreboard_pkg.sv | 31 +++
 rtl/issue_scoreboard_pending.sv | 62 ++++++
 rtl/issue_scoreboard.sv | 80 ++++++++
 tb/tb_issue_scoreboard.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue scoreboard: decoded instruction record, register index
// and per-register pending-counter types.
package issue_scoreboard_pkg;

  localparam int SB_CNT_W    = 2;
  localparam int SB_NUM_REGS = 32;
  localparam int REG_W       = 5;

  typedef logic [REG_W-1:0]    reg_idx;
  typedef logic [SB_CNT_W-1:0] sb_cnt;

  localparam sb_cnt SB_CNT_MAX = '1;

  typedef enum logic [2:0] {
    INSTR_INVAL  = 3'd0,
    INSTR_ADD    = 3'd1,
    INSTR_ADDI   = 3'd2,
    INSTR_LOAD   = 3'd3,
    INSTR_STORE  = 3'd4,
    INSTR_BRANCH = 3'd5
  } instr_op_e;

  typedef struct packed {
    instr_op_e   op;
    reg_idx      rd;
    reg_idx      rs1;
    reg_idx      rs2;
    logic [31:0] imm;
  } decoded_instr_t;

endpackage

// File: rtl/issue_scoreboard_pending.sv
// Per-GPR in-flight write counters: one increment port, two decrement ports,
// and combinational busy/full queries on the registered counts.
module sb_pending_file
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W    = SB_CNT_W,
  parameter int NUM_REGS = SB_NUM_REGS
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_inc_en,
  input  reg_idx i_inc_idx,
  input  logic   i_dec_a_en,
  input  reg_idx i_dec_a_idx,
  input  logic   i_dec_b_en,
  input  reg_idx i_dec_b_idx,
  input  reg_idx i_rs1,
  input  reg_idx i_rs2,
  input  reg_idx i_rd,
  output logic   o_rs1_busy,
  output logic   o_rs2_busy,
  output logic   o_rd_full
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt     [NUM_REGS];
  logic [CNT_W-1:0] w_cnt_nxt [NUM_REGS];
  logic [CNT_W+1:0] w_up      [NUM_REGS];
  logic [CNT_W+1:0] w_down    [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc_hit;
  logic [NUM_REGS-1:0] w_dec_a_hit;
  logic [NUM_REGS-1:0] w_dec_b_hit;
  logic [NUM_REGS-1:0] w_underflow;

  // x0 is never tracked; an increment and a decrement on the same register cancel.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_inc_hit[i]   = (i != 0) && i_inc_en   && (i_inc_idx   == reg_idx'(i));
      w_dec_a_hit[i] = (i != 0) && i_dec_a_en && (i_dec_a_idx == reg_idx'(i));
      w_dec_b_hit[i] = (i != 0) && i_dec_b_en && (i_dec_b_idx == reg_idx'(i));
      w_up[i]        = {2'b00, r_cnt[i]} + (CNT_W+2)'(w_inc_hit[i]);
      w_down[i]      = (CNT_W+2)'(w_dec_a_hit[i]) + (CNT_W+2)'(w_dec_b_hit[i]);
      w_underflow[i] = w_down[i] > w_up[i];
      w_cnt_nxt[i]   = w_underflow[i] ? '0 : CNT_W'(w_up[i] - w_down[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) r_cnt[i] <= '0;
      else     r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign o_rs1_busy = (i_rs1 != '0) && (r_cnt[i_rs1] != '0);
  assign o_rs2_busy = (i_rs2 != '0) && (r_cnt[i_rs2] != '0);
  assign o_rd_full  = (i_rd  != '0) && (r_cnt[i_rd] == CNT_MAX);

  a_no_underflow: assert property (@(posedge clk) disable iff (rst) w_underflow == '0);

endmodule

// File: rtl/issue_scoreboard.sv
// Single-slot issue stage between decode and execute; blocks RAW hazards and
// counter saturation using per-register pending-write counts.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W    = SB_CNT_W,
  parameter int NUM_REGS = SB_NUM_REGS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_decoded_valid,
  output logic           o_decoded_ready,
  input  decoded_instr_t i_decoded_data,
  output logic           o_issued_valid,
  input  logic           i_issued_ready,
  output decoded_instr_t o_issued_data,
  input  logic           i_wb_valid,
  input  reg_idx         i_wb_rd,
  input  logic           i_flush,
  output logic           o_stall_raw
);

  logic           r_valid;
  decoded_instr_t r_data;

  logic w_slot_free;
  logic w_rs1_busy;
  logic w_rs2_busy;
  logic w_rd_full;
  logic w_hazard;
  logic w_sat;
  logic w_accept;
  logic w_drop;

  assign w_slot_free = !r_valid || i_issued_ready;
  assign w_hazard    = w_rs1_busy || w_rs2_busy;
  // A retiring write to rd frees a counter slot this cycle, so a full counter may still accept.
  assign w_sat       = w_rd_full && !(i_wb_valid && (i_wb_rd == i_decoded_data.rd));

  assign o_decoded_ready = !rst && !i_flush && w_slot_free && !w_hazard && !w_sat;
  assign o_stall_raw     = i_decoded_valid && w_hazard;
  assign w_accept        = i_decoded_valid && o_decoded_ready;
  // A held instr that leaves during a flush still writes back, so only a stuck one is undone.
  assign w_drop          = i_flush && r_valid && !i_issued_ready;

  always_ff @(posedge clk) begin
    if (rst)                 r_valid <= 1'b0;
    else if (i_flush)        r_valid <= 1'b0;
    else if (w_accept)       r_valid <= 1'b1;
    else if (i_issued_ready) r_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_data <= i_decoded_data;
  end

  assign o_issued_valid = r_valid;
  assign o_issued_data  = r_data;

  sb_pending_file #(
    .CNT_W    (CNT_W),
    .NUM_REGS (NUM_REGS)
  ) u_pending (
    .clk         (clk),
    .rst         (rst),
    .i_inc_en    (w_accept),
    .i_inc_idx   (i_decoded_data.rd),
    .i_dec_a_en  (i_wb_valid),
    .i_dec_a_idx (i_wb_rd),
    .i_dec_b_en  (w_drop),
    .i_dec_b_idx (r_data.rd),
    .i_rs1       (i_decoded_data.rs1),
    .i_rs2       (i_decoded_data.rs2),
    .i_rd        (i_decoded_data.rd),
    .o_rs1_busy  (w_rs1_busy),
    .o_rs2_busy  (w_rs2_busy),
    .o_rd_full   (w_rd_full)
  );

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed sequences, a combinational
// vector table, and randomized traffic against a queue-based reference model.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           dv;
  logic           dec_ready;
  decoded_instr_t d;
  logic           iss_valid;
  logic           iss_ready;
  decoded_instr_t iss_data;
  logic           wb_valid;
  reg_idx         wb_rd;
  logic           flush;
  logic           stall_raw;

  int n_checks = 0;
  int n_errors = 0;

  localparam int PMAX = (1 << SB_CNT_W) - 1;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .i_decoded_valid (dv),
    .o_decoded_ready (dec_ready),
    .i_decoded_data  (d),
    .o_issued_valid  (iss_valid),
    .i_issued_ready  (iss_ready),
    .o_issued_data   (iss_data),
    .i_wb_valid      (wb_valid),
    .i_wb_rd         (wb_rd),
    .i_flush         (flush),
    .o_stall_raw     (stall_raw)
  );

  typedef struct {
    logic   valid;
    reg_idx rd;
    reg_idx rs1;
    reg_idx rs2;
    logic   wbv;
    reg_idx wbr;
    logic   fl;
    logic   exp_ready;
    logic   exp_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_d(input string name, input decoded_instr_t act, input decoded_instr_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic decoded_instr_t mk_i(input instr_op_e op, input int rd, input int rs1, input int rs2);
    decoded_instr_t x;
    x.op  = op;
    x.rd  = reg_idx'(rd);
    x.rs1 = reg_idx'(rs1);
    x.rs2 = reg_idx'(rs2);
    x.imm = $urandom;
    return x;
  endfunction

  function automatic vec_t mk_v(input logic v, input int rd, input int rs1, input int rs2,
                                input logic wbv, input int wbr, input logic fl,
                                input logic er, input logic es);
    vec_t t;
    t.valid = v; t.rd = reg_idx'(rd); t.rs1 = reg_idx'(rs1); t.rs2 = reg_idx'(rs2);
    t.wbv = wbv; t.wbr = reg_idx'(wbr); t.fl = fl; t.exp_ready = er; t.exp_stall = es;
    return t;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input int r);
    wb_valid = 1'b1;
    wb_rd    = reg_idx'(r);
    cycle();
    wb_valid = 1'b0;
    wb_rd    = '0;
  endtask

  // Reference model: instrs past the slot awaiting writeback, plus the held slot.
  reg_idx         q[$];
  logic           m_valid;
  decoded_instr_t m_data;

  function automatic int pend(input reg_idx r);
    int c = 0;
    foreach (q[k]) if (q[k] == r) c++;
    if (m_valid && m_data.rd == r) c++;
    return c;
  endfunction

  initial begin
    rst = 1'b1; dv = 1'b0; d = '0; iss_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;

    // Reset
    cycle(); cycle();
    chk("rst_iss_valid", iss_valid, 1'b0);
    chk("rst_dec_ready", dec_ready, 1'b0);
    rst = 1'b0;
    #1 chk("post_rst_ready", dec_ready, 1'b1);

    // Back-to-back independent
    iss_ready = 1'b1; dv = 1'b1;
    d = mk_i(INSTR_ADDI, 1, 0, 0);
    #1 chk("b2b_ready1", dec_ready, 1'b1);
    cycle();
    chk("b2b_valid1", iss_valid, 1'b1);
    chk_d("b2b_data1", iss_data, d);
    d = mk_i(INSTR_ADDI, 2, 0, 0);
    #1 chk("b2b_ready2", dec_ready, 1'b1);
    cycle();
    chk("b2b_valid2", iss_valid, 1'b1);
    chk_d("b2b_data2", iss_data, d);
    dv = 1'b0;
    cycle();
    chk("b2b_drain", iss_valid, 1'b0);
    retire(1); retire(2);

    // RAW: no same-cycle writeback bypass
    dv = 1'b1; d = mk_i(INSTR_ADDI, 5, 0, 0);
    cycle();
    d = mk_i(INSTR_ADD, 6, 5, 0);
    #1 chk("raw_stall", stall_raw, 1'b1);
    chk("raw_ready", dec_ready, 1'b0);
    cycle();
    chk("raw_stall2", stall_raw, 1'b1);
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1 chk("raw_no_bypass", dec_ready, 1'b0);
    cycle();
    wb_valid = 1'b0; wb_rd = '0;
    #1 chk("raw_ready_n1", dec_ready, 1'b1);
    chk("raw_stall_clr", stall_raw, 1'b0);
    cycle();
    chk("raw_issue_valid", iss_valid, 1'b1);
    chk_d("raw_issue_data", iss_data, d);
    dv = 1'b0;
    cycle();
    retire(6);

    // Saturation of x7
    dv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = mk_i(INSTR_ADDI, 7, 0, 0);
      #1 chk("sat_fill_ready", dec_ready, 1'b1);
      cycle();
    end
    d = mk_i(INSTR_ADDI, 7, 0, 0);
    #1 chk("sat_block", dec_ready, 1'b0);
    chk("sat_no_raw", stall_raw, 1'b0);
    wb_valid = 1'b1; wb_rd = 5'd7;
    #1 chk("sat_wb_release", dec_ready, 1'b1);
    cycle();
    wb_valid = 1'b0; wb_rd = '0;
    chk_d("sat_issue_data", iss_data, d);
    dv = 1'b0;
    cycle();
    retire(7); retire(7); retire(7);
    dv = 1'b1; d = mk_i(INSTR_ADD, 8, 7, 7);
    #1 chk("sat_drained", stall_raw, 1'b0);
    dv = 1'b0;
    cycle();

    // Flush of a held instr
    iss_ready = 1'b0; dv = 1'b1;
    d = mk_i(INSTR_ADDI, 9, 0, 0);
    cycle();
    chk("fl_held_valid", iss_valid, 1'b1);
    chk_d("fl_held_data", iss_data, d);
    m_data = d;
    d = mk_i(INSTR_ADDI, 11, 0, 0);
    #1 chk("fl_slot_busy", dec_ready, 1'b0);
    cycle();
    chk_d("fl_data_stable", iss_data, m_data);
    dv = 1'b0; flush = 1'b1;
    #1 chk("fl_ready", dec_ready, 1'b0);
    cycle();
    flush = 1'b0;
    chk("fl_valid_clr", iss_valid, 1'b0);
    dv = 1'b1; d = mk_i(INSTR_ADD, 10, 9, 0);
    #1 chk("fl_no_stall", stall_raw, 1'b0);
    chk("fl_consumer_ready", dec_ready, 1'b1);
    iss_ready = 1'b1;
    cycle();
    chk_d("fl_consumer_data", iss_data, d);
    dv = 1'b0;
    cycle();
    retire(10);

    // x0 is never tracked
    dv = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d = mk_i((k % 2) ? INSTR_INVAL : INSTR_ADDI, 0, 0, 0);
      wb_valid = 1'b1; wb_rd = '0;
      #1 chk("x0_ready", dec_ready, 1'b1);
      cycle();
      chk_d("x0_passthru", iss_data, d);
    end
    wb_valid = 1'b0;
    d = mk_i(INSTR_ADD, 3, 0, 0);
    #1 chk("x0_read_no_stall", stall_raw, 1'b0);
    cycle();
    dv = 1'b0;
    cycle();
    retire(3);

    // Combinational table with pending[5]=1, pending[7]=3, slot empty
    dv = 1'b1;
    d = mk_i(INSTR_ADDI, 5, 0, 0); cycle();
    for (int k = 0; k < 3; k++) begin
      d = mk_i(INSTR_ADDI, 7, 0, 0); cycle();
    end
    dv = 1'b0;
    cycle();
    vecs.push_back(mk_v(1, 1, 5, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk_v(1, 1, 0, 5, 0, 0, 0, 0, 1));
    vecs.push_back(mk_v(1, 1, 7, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk_v(1, 1, 3, 4, 0, 0, 0, 1, 0));
    vecs.push_back(mk_v(1, 7, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk_v(1, 7, 0, 0, 1, 7, 0, 1, 0));
    vecs.push_back(mk_v(1, 7, 0, 0, 1, 5, 0, 0, 0));
    vecs.push_back(mk_v(1, 5, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk_v(1, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk_v(1, 1, 5, 0, 1, 5, 0, 0, 1));
    vecs.push_back(mk_v(1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk_v(1, 2, 7, 5, 0, 0, 1, 0, 1));
    vecs.push_back(mk_v(0, 1, 5, 0, 0, 0, 0, 0, 0));
    foreach (vecs[k]) begin
      dv = vecs[k].valid;
      d = mk_i(INSTR_ADD, int'(vecs[k].rd), int'(vecs[k].rs1), int'(vecs[k].rs2));
      wb_valid = vecs[k].wbv; wb_rd = vecs[k].wbr; flush = vecs[k].fl;
      #1;
      chk($sformatf("tbl%0d_ready", k), dec_ready, vecs[k].exp_ready);
      chk($sformatf("tbl%0d_stall", k), stall_raw, vecs[k].exp_stall);
      dv = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
      cycle();
    end
    retire(5); retire(7); retire(7); retire(7);

    // Randomized traffic against the reference model
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    m_valid = 1'b0;
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      int  idx;
      logic haz, sat, exp_ready, exp_stall;
      chk("rnd_valid", iss_valid, m_valid);
      if (m_valid) chk_d("rnd_data", iss_data, m_data);
      dv        = 1'($urandom_range(0, 1));
      d         = mk_i(instr_op_e'($urandom_range(0, 5)), $urandom_range(0, 7),
                       $urandom_range(0, 7), $urandom_range(0, 7));
      iss_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      idx = -1;
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, q.size() - 1);
        wb_valid = 1'b1; wb_rd = q[idx];
      end else begin
        wb_valid = ($urandom_range(0, 7) == 0); wb_rd = '0;
      end
      haz = (d.rs1 != 0 && pend(d.rs1) > 0) || (d.rs2 != 0 && pend(d.rs2) > 0);
      sat = (d.rd != 0) && (pend(d.rd) == PMAX) && !(wb_valid && wb_rd == d.rd);
      exp_ready = !flush && (!m_valid || iss_ready) && !haz && !sat;
      exp_stall = dv && haz;
      #1;
      chk("rnd_ready", dec_ready, exp_ready);
      chk("rnd_stall", stall_raw, exp_stall);
      if (idx >= 0) q.delete(idx);
      if (m_valid && iss_ready && m_data.rd != 0) q.push_back(m_data.rd);
      if (flush)                  m_valid = 1'b0;
      else if (dv && exp_ready)   begin m_valid = 1'b1; m_data = d; end
      else if (iss_ready)         m_valid = 1'b0;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
